// File: rtl/finish_banner_ctrl_if.sv
// Bundle of game-side strobes/positions in and banner status out for finish_banner_ctrl.
// The game/test side uses the master modport; the banner controller uses the slave modport.
interface finish_banner_ctrl_if #(
  parameter int unsigned POS_W = 4
);
  logic             frame_start;
  logic             pos_valid;
  logic [POS_W-1:0] p1_pos;
  logic [POS_W-1:0] p2_pos;
  logic             restart;
  logic             finish_en;
  logic [1:0]       winner;
  logic             game_over;
  logic             banner_done;

  modport master (
    output frame_start, pos_valid, p1_pos, p2_pos, restart,
    input  finish_en, winner, game_over, banner_done
  );

  modport slave (
    input  frame_start, pos_valid, p1_pos, p2_pos, restart,
    output finish_en, winner, game_over, banner_done
  );
endinterface

// File: rtl/finish_banner_ctrl.sv
// finish_banner_ctrl: latches the winner when a player reaches the final tile and
// drives the FINISH banner enable, changing it only on frame boundaries.
// Optional feature macro FINISH_BLINK_EN: when defined the banner blinks during
// the show phase; when undefined it is steady on for the whole show phase.
module finish_banner_ctrl #(
  parameter int unsigned TILE_COUNT   = 10,
  parameter int unsigned POS_W        = 4,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned SHOW_FRAMES  = 180
) (
  input  logic                 clk,
  input  logic                 reset,
  finish_banner_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARM, BLINK, HOLD} state_t;

  localparam int K_W = $clog2(SHOW_FRAMES + 1);
  localparam logic [K_W-1:0] SHOW_K = K_W'(SHOW_FRAMES);

  state_t state_q, state_d;

  logic [K_W-1:0] frame_cnt_q, frame_cnt_d;
  logic           finish_en_q, finish_en_d;
  logic [1:0]     winner_q, winner_d;
  logic           game_over_q, game_over_d;
  logic           banner_done_q, banner_done_d;

`ifdef FINISH_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_FRAMES - 1);

  logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
`endif

  logic [POS_W-1:0] p1_pos;
  logic [POS_W-1:0] p2_pos;
  logic             p1_fin;
  logic             p2_fin;
  logic             detect;
  logic             restart_hit;
  logic [K_W-1:0]   frame_cnt_inc;
  logic             last_frame;

  assign p1_pos        = bus.p1_pos;
  assign p2_pos        = bus.p2_pos;
  assign p1_fin        = 32'(p1_pos) >= TILE_COUNT;
  assign p2_fin        = 32'(p2_pos) >= TILE_COUNT;
  assign detect        = bus.pos_valid && !bus.restart && (p1_fin || p2_fin);
  assign restart_hit   = bus.restart && (state_q != IDLE);
  assign frame_cnt_inc = frame_cnt_q + K_W'(1);
  assign last_frame    = (frame_cnt_inc == SHOW_K);

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; restart outside IDLE overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (detect) state_d = ARM;
      ARM:   if (bus.frame_start) state_d = BLINK;
      BLINK: if (bus.frame_start && last_frame) state_d = HOLD;
      HOLD:  state_d = HOLD;
    endcase
    if (restart_hit) begin
      state_d = IDLE;
    end
  end

  // Output and counter next values; finish_en only moves on a frame_start.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    finish_en_d   = finish_en_q;
    winner_d      = winner_q;
    game_over_d   = game_over_q;
    banner_done_d = 1'b0;
`ifdef FINISH_BLINK_EN
    blink_cnt_d   = blink_cnt_q;
    phase_d       = phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (detect) begin
          winner_d    = {p2_fin, p1_fin};
          game_over_d = 1'b1;
        end
      end
      ARM: begin
        if (bus.frame_start) begin
          frame_cnt_d = '0;
          finish_en_d = 1'b1;
`ifdef FINISH_BLINK_EN
          blink_cnt_d = '0;
          phase_d     = 1'b0;
`endif
        end
      end
      BLINK: begin
        if (bus.frame_start) begin
          frame_cnt_d = frame_cnt_inc;
          if (last_frame) begin
            finish_en_d   = 1'b1;
            banner_done_d = 1'b1;
          end else begin
`ifdef FINISH_BLINK_EN
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BC_W'(1);
            end
            finish_en_d = ~phase_d;
`else
            finish_en_d = 1'b1;
`endif
          end
        end
      end
      HOLD: begin
        finish_en_d = 1'b1;
      end
    endcase
    if (restart_hit) begin
      frame_cnt_d   = '0;
      finish_en_d   = 1'b0;
      winner_d      = 2'd0;
      game_over_d   = 1'b0;
      banner_done_d = 1'b0;
`ifdef FINISH_BLINK_EN
      blink_cnt_d   = '0;
      phase_d       = 1'b0;
`endif
    end
  end

  // Registered outputs and counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      finish_en_q   <= 1'b0;
      winner_q      <= 2'd0;
      game_over_q   <= 1'b0;
      banner_done_q <= 1'b0;
`ifdef FINISH_BLINK_EN
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
`endif
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      finish_en_q   <= finish_en_d;
      winner_q      <= winner_d;
      game_over_q   <= game_over_d;
      banner_done_q <= banner_done_d;
`ifdef FINISH_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
`endif
    end
  end

  assign bus.finish_en   = finish_en_q;
  assign bus.winner      = winner_q;
  assign bus.game_over   = game_over_q;
  assign bus.banner_done = banner_done_q;

endmodule

// File: doc/finish_banner_ctrl.md
# finish_banner_ctrl

Game-side producer of the `finish_en` level consumed by the FINISH text renderer in the UI render path. Watches committed player tile positions, latches the winner when a player reaches the final tile, then drives `finish_en` with a frame-synchronous blink sequence followed by a steady hold until the game is restarted. All `finish_en` changes land on frame boundaries so the renderer never shows a torn banner.

## Interface
- `TILE_COUNT`, 10: finishing tile index; a position `>= TILE_COUNT` counts as finished.
- `POS_W`, 4: width of player position inputs.
- `BLINK_FRAMES`, 15: frames per blink half-period (on or off); must be >= 1.
- `SHOW_FRAMES`, 180: frames spent in the blink phase before steady hold; must be >= 1.

- `clk`  in  1: pixel/system clock.
- `reset`  in  1: synchronous, active-high reset.
- `frame_start`  in  1: one-cycle pulse at the start of each video frame (vsync edge).
- `pos_valid`  in  1: one-cycle pulse; `p1_pos`/`p2_pos` hold newly committed positions.
- `p1_pos`  in  POS_W: player 1 tile position.
- `p2_pos`  in  POS_W: player 2 tile position.
- `restart`  in  1: one-cycle pulse; returns the block to idle.
- `finish_en`  out  1: banner enable to the renderer (registered).
- `winner`  out  2: 0 none, 1 player 1, 2 player 2, 3 tie (registered).
- `game_over`  out  1: high from detection until restart (registered).
- `banner_done`  out  1: one-cycle pulse on entry to HOLD.

## Operation
- States: IDLE, ARM, BLINK, HOLD.
- IDLE: `pos_valid` with either position `>= TILE_COUNT` -> ARM; latch `winner` (1, 2, or 3 if both finished on the same `pos_valid`); `game_over` <= 1. `pos_valid` without a finisher is ignored.
- ARM: wait for `frame_start`; on it -> BLINK, frame index k = 0, `finish_en` <= 1.
- BLINK: each `frame_start` increments k. For frame k, `finish_en` = 1 when `(k / BLINK_FRAMES)` is even, else 0. Implemented with a blink counter wrapping at `BLINK_FRAMES-1` and a phase toggle — no divider. When k reaches `SHOW_FRAMES` -> HOLD, `finish_en` <= 1, `banner_done` pulses.
- HOLD: `finish_en` steady 1 until `restart`.
- `winner` is frozen from detection until `restart`/`reset`; later `pos_valid` pulses are ignored outside IDLE.
- `restart` in any non-IDLE state -> IDLE next cycle, clearing `finish_en`, `game_over`, `winner`, and the counters. It takes effect immediately, not frame-aligned. `restart` in IDLE has no effect.
- Simultaneous `restart` and `pos_valid`: restart wins; no detection that cycle.
- Counter widths: frame counter `$clog2(SHOW_FRAMES+1)` bits; blink counter `$clog2(BLINK_FRAMES)` bits, minimum 1. No wrap occurs within BLINK.

## Timing
- Reset values: state IDLE, `finish_en` 0, `winner` 0, `game_over` 0, `banner_done` 0, counters 0.
- Detection latency: `winner`/`game_over` valid 1 cycle after the `pos_valid` edge.
- `frame_start` in the same cycle as detecting `pos_valid` does not count; the block uses the next `frame_start`.
- `finish_en` rises 1 cycle after the first `frame_start` seen in ARM. Every blink transition also appears 1 cycle after its `frame_start`.
- `banner_done` is high exactly 1 cycle, coincident with the HOLD entry edge.
- `reset` mid-sequence has the same effect as power-on reset on the next edge.

## Configuration
- `FINISH_BLINK_EN` defined: blink behaviour as above.
- Not defined: blink counter and phase logic removed. `finish_en` is steady 1 throughout BLINK. BLINK still lasts `SHOW_FRAMES` frames and still pulses `banner_done` on entry to HOLD.

## Test plan
- Reset, then `pos_valid` with p1=3, p2=9 -> stays IDLE, all outputs 0.
- `BLINK_FRAMES`=2, `SHOW_FRAMES`=6, macro defined; `pos_valid` with p1=10, p2=4, then 7 `frame_start`s -> `winner`=1, `game_over`=1. `finish_en` per frame k0..k5 is 1,1,0,0,1,1; at k6 it is 1 and `banner_done` pulses once.
- `pos_valid` with p1=10, p2=12 -> `winner`=3. A later `pos_valid` with p1=2 leaves `winner`=3.
- `pos_valid` (p2=10) and `frame_start` in the same cycle -> `finish_en` stays 0 until 1 cycle after the next `frame_start`.
- `restart` during BLINK at k=3 -> next cycle IDLE, all outputs 0. `restart` coincident with a finishing `pos_valid` -> stays IDLE.
- Macro undefined, same stimulus as scenario 2 -> `finish_en` 1 for frames k0..k5 and in HOLD; `banner_done` pulses at k6.
